// File: rtl/id_ex_pipe_if.sv
// Decode-stage bundle presented to the ID/EX pipeline register.
// The decoder drives it through the master modport; id_ex_pipe samples it through the slave modport.
interface id_ex_pipe_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            rf_en;
    logic            mem_rd;
    logic            mem_wr;
    logic [3:0]      alu_op;
    logic [1:0]      wb_sel;

    modport master (
        output valid, pc, rs1, rs2, rd, uses_rs1, uses_rs2,
               rs1_data, rs2_data, imm, rf_en, mem_rd, mem_wr, alu_op, wb_sel
    );
    modport slave (
        input  valid, pc, rs1, rs2, rd, uses_rs1, uses_rs2,
               rs1_data, rs2_data, imm, rf_en, mem_rd, mem_wr, alu_op, wb_sel
    );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use interlock, stall/flush handling
// and a wrapping counter of interlock bubbles.
module id_ex_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    id_ex_pipe_if.slave     id,
    input  logic            ext_stall,
    input  logic            flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic            ex_rf_en,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr,
    output logic [3:0]      ex_alu_op,
    output logic [1:0]      ex_wb_sel,
    output logic            stall_if_id,
    output logic            load_use_hazard,
    output logic [XLEN-1:0] bubble_cnt
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            rf_en;
        logic            mem_rd;
        logic            mem_wr;
        logic [3:0]      alu_op;
        logic [1:0]      wb_sel;
    } ex_t;

    ex_t             ex_reg;
    ex_t             ex_next;
    logic [XLEN-1:0] cnt_reg;
    logic [XLEN-1:0] cnt_next;
    logic            rs1_match;
    logic            rs2_match;
    logic            hz;

    // A bubble is all-zero, so rd/rs fields of 0 steer forwarding to the register file.
    assign rs1_match = id.uses_rs1 && (id.rs1 == ex_reg.rd);
    assign rs2_match = id.uses_rs2 && (id.rs2 == ex_reg.rd);
    assign hz = id.valid && ex_reg.valid && ex_reg.mem_rd && (ex_reg.rd != 5'd0)
                && (rs1_match || rs2_match);

    assign load_use_hazard = hz && !flush && !ext_stall;
    assign stall_if_id     = ext_stall || load_use_hazard;

    always_comb begin
        ex_next  = ex_reg;
        cnt_next = cnt_reg;
        if (ext_stall) begin
            ex_next = ex_reg;
        end else if (flush) begin
            ex_next = '0;
        end else if (load_use_hazard) begin
            ex_next  = '0;
            cnt_next = cnt_reg + 1'b1;
        end else begin
            ex_next.valid    = id.valid;
            ex_next.pc       = id.pc;
            ex_next.rs1      = id.rs1;
            ex_next.rs2      = id.rs2;
            ex_next.rd       = id.rd;
            ex_next.rs1_data = id.rs1_data;
            ex_next.rs2_data = id.rs2_data;
            ex_next.imm      = id.imm;
            // Side-effecting controls are suppressed for an invalid slot.
            ex_next.rf_en    = id.valid && id.rf_en;
            ex_next.mem_rd   = id.valid && id.mem_rd;
            ex_next.mem_wr   = id.valid && id.mem_wr;
            ex_next.alu_op   = id.alu_op;
            ex_next.wb_sel   = id.wb_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg  <= '0;
            cnt_reg <= '0;
        end else begin
            ex_reg  <= ex_next;
            cnt_reg <= cnt_next;
        end
    end

    assign ex_valid    = ex_reg.valid;
    assign ex_pc       = ex_reg.pc;
    assign ex_rs1      = ex_reg.rs1;
    assign ex_rs2      = ex_reg.rs2;
    assign ex_rd       = ex_reg.rd;
    assign ex_rs1_data = ex_reg.rs1_data;
    assign ex_rs2_data = ex_reg.rs2_data;
    assign ex_imm      = ex_reg.imm;
    assign ex_rf_en    = ex_reg.rf_en;
    assign ex_mem_rd   = ex_reg.mem_rd;
    assign ex_mem_wr   = ex_reg.mem_wr;
    assign ex_alu_op   = ex_reg.alu_op;
    assign ex_wb_sel   = ex_reg.wb_sel;
    assign bubble_cnt  = cnt_reg;
endmodule
